// File: rtl/layer4_window_fetch.sv
// layer4_window_fetch: scans a 14x14 layer-3 map in raster order, fetches each 3x3 window of words and presents it over valid/ready
module layer4_window_fetch #(
  parameter int IN_W = 14,
  parameter int K = 3,
  parameter int DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           read_row_addr,
  output logic [15:0]           read_col_addr,
  output logic                  layer3_result_read_signal,
  input  logic [DATA_W-1:0]     layer3_result_output,
  output logic                  window_valid,
  input  logic                  window_ready,
  output logic [K*K*DATA_W-1:0] window_data,
  output logic [15:0]           out_row,
  output logic [15:0]           out_col
);
  localparam int OUT_W = IN_W - K + 1;
  localparam logic [3:0] LAST_POS = 4'(OUT_W - 1);
  localparam logic [3:0] LAST_TAP = 4'(K * K - 1);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, PRESENT} state_t;
  state_t r_state, w_next;
  logic [3:0] r_tap, r_prow, r_pcol, r_orow, r_ocol;
  logic [3:0] w_tn, w_ky, w_kx, w_nprow, w_npcol, w_brow, w_bcol;
  logic [15:0] r_row, r_col;
  logic r_done;
  logic [(K*K-1)*DATA_W-1:0] r_asm;
  logic [K*K*DATA_W-1:0] r_win;
  logic w_xfer, w_last, w_ld0, w_ldn;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_xfer = r_state == PRESENT && window_ready;
    w_last = r_prow == LAST_POS && r_pcol == LAST_POS;
    unique case (r_state)
      IDLE:    w_next = start ? FETCH : IDLE;
      FETCH:   w_next = r_tap == LAST_TAP ? DRAIN : FETCH;
      DRAIN:   w_next = PRESENT;
      default: w_next = w_xfer ? (w_last ? IDLE : FETCH) : PRESENT;
    endcase
    w_npcol = r_pcol == LAST_POS ? 4'd0 : r_pcol + 4'd1;
    w_nprow = r_pcol == LAST_POS ? r_prow + 4'd1 : r_prow;
    w_ld0 = (r_state == IDLE && start) || (w_xfer && !w_last);
    w_ldn = r_state == FETCH && r_tap != LAST_TAP;
    w_tn = w_ldn ? r_tap + 4'd1 : 4'd0;
    w_ky = 4'(w_tn / 4'(K));
    w_kx = 4'(w_tn % 4'(K));
    w_brow = r_state == PRESENT ? w_nprow : r_prow;
    w_bcol = r_state == PRESENT ? w_npcol : r_pcol;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_tap <= '0;
      r_prow <= '0;
      r_pcol <= '0;
      r_orow <= '0;
      r_ocol <= '0;
      r_row <= '0;
      r_col <= '0;
      r_done <= 1'b0;
      r_asm <= '0;
      r_win <= '0;
    end else begin
      r_done <= w_xfer && w_last;
      if (r_state == FETCH) r_tap <= r_tap == LAST_TAP ? 4'd0 : r_tap + 4'd1;
      if (w_ld0 || w_ldn) begin
        r_row <= 16'(w_brow + w_ky);
        r_col <= 16'(w_bcol + w_kx);
      end
      if (r_state == FETCH && r_tap != 4'd0) r_asm[32'(r_tap - 4'd1) * DATA_W +: DATA_W] <= layer3_result_output;
      if (r_state == DRAIN) begin
        r_win <= {layer3_result_output, r_asm};
        r_orow <= r_prow;
        r_ocol <= r_pcol;
      end
      if (w_xfer) begin
        r_prow <= w_last ? 4'd0 : w_nprow;
        r_pcol <= w_last ? 4'd0 : w_npcol;
      end
    end
  assign busy = r_state != IDLE;
  assign done = r_done;
  assign read_row_addr = r_row;
  assign read_col_addr = r_col;
  assign layer3_result_read_signal = r_state == FETCH || r_state == DRAIN;
  assign window_valid = r_state == PRESENT;
  assign window_data = r_win;
  assign out_row = {12'd0, r_orow};
  assign out_col = {12'd0, r_ocol};
endmodule

// File: tb/tb_layer4_window_fetch.sv
// tb_layer4_window_fetch: directed checks of the layer-4 window fetch sequencer against a behavioural memory and window model
module tb_layer4_window_fetch;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, window_ready = 1'b0;
  logic busy, done, rd, window_valid;
  logic [15:0] row_a, col_a, out_row, out_col;
  logic [127:0] mem_q = '0;
  logic [1151:0] window_data;
  int tests = 0, fails = 0;
  typedef struct {int cyc; logic rs; logic valid; int row; int col;} vec_t;
  vec_t tbl[11];
  layer4_window_fetch dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .read_row_addr(row_a), .read_col_addr(col_a), .layer3_result_read_signal(rd),
    .layer3_result_output(mem_q), .window_valid(window_valid), .window_ready(window_ready),
    .window_data(window_data), .out_row(out_row), .out_col(out_col)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] word(input int r, input int c);
    return {4{16'(r), 16'(c)}};
  endfunction
  function automatic logic [1151:0] win(input int r, input int c);
    logic [1151:0] w;
    for (int k = 0; k < 9; k++) w[k*128 +: 128] = word(r + k / 3, c + k % 3);
    return w;
  endfunction
  always @(posedge clk) if (rd) mem_q <= word(int'(row_a), int'(col_a));
  task automatic chk(input string name, input logic [1151:0] act, input logic [1151:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " valid"}, window_valid, 0);
    chk({tag, " rd"}, rd, 0);
    chk({tag, " addr"}, {row_a, col_a}, 0);
    chk({tag, " out_pos"}, {out_row, out_col}, 0);
    chk({tag, " data"}, window_data, 0);
  endtask
  task automatic run_frame(input int hold_win, input int glitch, input bit chain);
    int cyc, nx, nd, dcyc, rsc, hold, bad_addr, bad_stab, bad_rs, sr, sc;
    logic [1151:0] snap;
    logic pv;
    cyc = 0; nx = 0; nd = 0; dcyc = -1; rsc = 0; hold = 0;
    bad_addr = 0; bad_stab = 0; bad_rs = 0; sr = 0; sc = 0; snap = '0; pv = 1'b0;
    window_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (nd == 0 && cyc < 4000) begin
      if (rd) begin
        rsc++;
        if (row_a > 16'd13 || col_a > 16'd13) bad_addr++;
      end
      if (window_valid && !pv) begin
        chk("win_data", window_data, win(nx / 12, nx % 12));
        chk("out_row", out_row, nx / 12);
        chk("out_col", out_col, nx % 12);
        chk("rd_cycles", rsc, 10);
        rsc = 0; snap = window_data; sr = int'(out_row); sc = int'(out_col);
        if (nx == hold_win) hold = 20;
      end
      if (window_valid && pv && (window_data !== snap || int'(out_row) != sr || int'(out_col) != sc)) bad_stab++;
      if (hold > 0 && (rd || !window_valid)) bad_rs++;
      if (done) begin
        nd++;
        dcyc = cyc;
        chk("busy_at_done", busy, 0);
      end
      window_ready = hold == 0;
      if (hold > 0) hold--;
      if (window_valid && window_ready) nx++;
      pv = window_valid;
      start = cyc == glitch || (done && chain);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("xfers", nx, 144);
    chk("dones", nd, 1);
    chk("done_cycle", dcyc, hold_win >= 0 ? 1604 : 1584);
    chk("addr_bound", bad_addr, 0);
    chk("hold_stable", bad_stab, 0);
    chk("hold_rd_low", bad_rs, 0);
    chk("done_single", done, 0);
    chk("busy_after", busy, chain);
  endtask
  initial begin
    tbl[0]  = '{0, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{1, 1'b1, 1'b0, 0, 1};
    tbl[2]  = '{2, 1'b1, 1'b0, 0, 2};
    tbl[3]  = '{3, 1'b1, 1'b0, 1, 0};
    tbl[4]  = '{4, 1'b1, 1'b0, 1, 1};
    tbl[5]  = '{5, 1'b1, 1'b0, 1, 2};
    tbl[6]  = '{6, 1'b1, 1'b0, 2, 0};
    tbl[7]  = '{7, 1'b1, 1'b0, 2, 1};
    tbl[8]  = '{8, 1'b1, 1'b0, 2, 2};
    tbl[9]  = '{9, 1'b1, 1'b0, 2, 2};
    tbl[10] = '{10, 1'b0, 1'b1, 2, 2};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("c%0d rd", tbl[i].cyc), rd, tbl[i].rs);
      chk($sformatf("c%0d valid", tbl[i].cyc), window_valid, tbl[i].valid);
      chk($sformatf("c%0d row", tbl[i].cyc), row_a, tbl[i].row);
      chk($sformatf("c%0d col", tbl[i].cyc), col_a, tbl[i].col);
      chk($sformatf("c%0d busy", tbl[i].cyc), busy, 1);
    end
    chk("first_window", window_data, win(0, 0));
    chk("first_pos", {out_row, out_col}, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_frame(-1, -1, 1'b1);
    repeat (334) @(negedge clk);
    chk("w30_row_addr", row_a, 3);
    chk("w30_col_addr", col_a, 7);
    chk("w30_prev_pos", {out_row, out_col}, {16'd2, 16'd5});
    chk("w30_rd", rd, 1);
    #1 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(5, 3, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/layer4_window_fetch.md
# layer4_window_fetch

Sequencer directly downstream of the layer-3 result memory. It walks the 14×14 layer-3 feature map in raster order and, for every valid 3×3 convolution position, issues nine reads on the memory's row/column read port. It assembles the nine 128-bit channel words into one window and hands that window to the layer-4 convolution engine over a valid/ready handshake.

## Interface
- IN_W, default 14: feature-map side, in pixels; memory row stride is also 14.
- K, default 3: kernel side.
- DATA_W, default 128: bits per pixel word (`LAYER3_OUTPUT_LENGTH).
- clk, in, 1: sole clock; all state changes on its rising edge.
- rst, in, 1: reset, asynchronous and active-high.
- start, in, 1: one-cycle pulse that begins a frame scan; sampled only in IDLE.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the last window is accepted.
- read_row_addr, out, 16: row address to the layer-3 memory read port.
- read_col_addr, out, 16: column address to the layer-3 memory read port.
- layer3_result_read_signal, out, 1: memory read enable and output gate.
- layer3_result_output, in, DATA_W: memory read data, valid one cycle after address.
- window_valid, out, 1: the window is held stable.
- window_ready, in, 1: consumer accepts the window.
- window_data, out, K*K*DATA_W: tap k = ky*K+kx occupies bits [k*DATA_W +: DATA_W].
- out_row, out, 16: output-position row of the presented window.
- out_col, out, 16: output-position column of the presented window.

## Operation
- OUT_W = IN_W−K+1 (12). Positions are scanned out_row 0..11 outer, out_col 0..11 inner, for 144 windows per frame.
- FSM states:
  - IDLE → FETCH on start.
  - FETCH: 9 issue cycles, tap counter 0..8.
  - DRAIN: 1 cycle to capture tap 8.
  - PRESENT: hold until window_valid && window_ready. Then go to FETCH for the next position, or to IDLE with a done pulse after position (11,11).
- Address for tap (ky,kx): read_row_addr = out_row+ky, read_col_addr = out_col+kx. Both are zero-extended to 16 bits and never exceed 13.
- layer3_result_read_signal is high for all FETCH cycles and the DRAIN cycle, and low otherwise.
- The word captured at cycle t is the word for the tap issued at t−1. Tap k is written into slot k, and the other slots hold.
- The window register is fully rewritten for each position; there is no data reuse between positions.
- Outside FETCH/DRAIN, read addresses hold their last value. They are 0 after reset.
- window_data, out_row and out_col change only on entry to PRESENT. They are stable while window_valid is high.
- start is ignored in any state other than IDLE.
- Counter arithmetic: the 4-bit tap counter wraps 8→0 on leaving FETCH. Position counters are 4 bits, compared against OUT_W−1, and zero-extended on output.

## Timing
- Reset values:
  - busy, done, window_valid and layer3_result_read_signal: 0.
  - read_row_addr, read_col_addr, out_row and out_col: 0.
  - window_data: all 0.
  - FSM in IDLE; counters at 0.
- Cycle 0 is the first FETCH cycle, immediately after start is sampled high.
  - Address tap k is driven in cycle k.
  - Data for tap k is captured at the end of cycle k+1.
  - window_valid rises in cycle 10.
- With window_ready held high, the minimum per-window period is 11 cycles (9 FETCH + 1 DRAIN + 1 PRESENT). A full frame takes 144×11 = 1584 cycles from start to the done pulse.
- Handshake:
  - Transfer occurs on a cycle with window_valid && window_ready.
  - window_valid drops in the next cycle unless the FSM is entering PRESENT again, which is impossible.
  - window_ready arriving before window_valid has no effect.
- done is high in the cycle after the final transfer, together with busy falling. A start pulse in that same cycle is accepted, because the FSM is already in IDLE.
- Asynchronous rst at any point, including mid-FETCH or mid-PRESENT, forces all reset values immediately. No partial window is presented afterwards.

## Test plan
- Reset, then start; memory word at row r, col c = {r,c} pattern → first window taps hold (0,0),(0,1),(0,2),(1,0)…(2,2). window_valid rises 10 cycles after start, with out_row=0 and out_col=0.
- Full frame with window_ready tied to 1 → exactly 144 transfers, the last with out_row=11 and out_col=11 and tap 8 = word (13,13). done pulses once, 1584 cycles after start.
- window_ready held low 20 cycles on window 5 → window_valid, window_data and out_col=5 stay stable the whole time, layer3_result_read_signal stays 0, and the scan resumes on release.
- start pulsed at cycle 3 of a scan → ignored. The transfer count is still 144, with a single done.
- rst asserted during FETCH tap 4 of window 30 → all outputs 0 in the same cycle. A following start restarts at position (0,0).
- Check every layer3_result_read_signal cycle → read_row_addr ≤ 13 and read_col_addr ≤ 13. The read signal is high for exactly 10 cycles per window.
